hazard_scoreboard: RTL and testbench

Parametrised scoreboard hazard unit for the ID stage, replacing fixed EXE/MEM destination compares with per-register countdown counters. It tracks every in-flight write by remaining latency, so variable-latency producers (loads, multi-cycle ops) are handled without extra pipeline taps. Its stall output gates the IF/ID pipeline registers and injects a bubble into EXE.

---
 rtl/hazard_scoreboard_pkg.sv | 24 ++
 rtl/hazard_scoreboard_cnt_cell.sv | 33 +++
 rtl/hazard_scoreboard.sv | 78 +++++++
 tb/tb_hazard_scoreboard.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared defaults, latency constants and the counter update helper
// for the hazard scoreboard.
package hazard_pkg;

    localparam int REG_ADDR_W_DEF = 4;
    localparam int LAT_W_DEF      = 3;
    localparam int PERF_W_DEF     = 16;

    localparam int LAT_ALU_FWD  = 0;
    localparam int LAT_LOAD_FWD = 1;
    localparam int LAT_WB       = 2;

    // Decrement saturating at zero, then keep the longer of the two
    // so an older in-flight writer stays pending.
    function automatic int unsigned sat_dec_max(
        input int unsigned c,
        input int unsigned l
    );
        int unsigned d;
        d = (c == 0) ? 0 : c - 1;
        return (d > l) ? d : l;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_cnt_cell.sv
// One per-register countdown: load with max, decrement, or hold
// while the pipeline is frozen.
module hazard_cnt_cell
    import hazard_pkg::*;
#(
    parameter int LAT_W = LAT_W_DEF
) (
    input  logic             clk,
    input  logic             i_rst,
    input  logic             i_freeze,
    input  logic             i_load,
    input  logic [LAT_W-1:0] i_lat,
    output logic [LAT_W-1:0] o_cnt
);

    logic [LAT_W-1:0] r_cnt;
    logic [LAT_W-1:0] w_dec;
    logic [LAT_W-1:0] w_ld;

    assign w_dec = (r_cnt == '0) ? '0 : r_cnt - 1'b1;
    assign w_ld  = LAT_W'(sat_dec_max(32'(r_cnt), 32'(i_lat)));

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (!i_freeze) begin
            r_cnt <= i_load ? w_ld : w_dec;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage scoreboard hazard unit with per-register latency counters.
// Define HAZARD_FWD_EN to load counters from fwd_lat instead of wb_lat.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int LAT_W      = LAT_W_DEF,
    parameter int PERF_W     = PERF_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       issue_valid,
    input  logic                       disabled,
    input  logic                       freeze,
    input  logic                       flush,
    input  logic [REG_ADDR_W-1:0]      src1,
    input  logic [REG_ADDR_W-1:0]      src2,
    input  logic                       two_src,
    input  logic                       wb_en,
    input  logic [REG_ADDR_W-1:0]      dest,
    input  logic [LAT_W-1:0]           fwd_lat,
    input  logic [LAT_W-1:0]           wb_lat,
    output logic                       stall,
    output logic [2**REG_ADDR_W-1:0]   busy_vec,
    output logic [PERF_W-1:0]          stall_cycles
);

    localparam int NUM_REGS = 2**REG_ADDR_W;

    logic [LAT_W-1:0]    w_cnt [NUM_REGS];
    logic [NUM_REGS-1:0] w_busy;
    logic [LAT_W-1:0]    w_lat;
    logic                w_hit;
    logic                w_acc;
    logic [PERF_W-1:0]   r_stall_cycles;

`ifdef HAZARD_FWD_EN
    logic w_unused_lat;
    assign w_unused_lat = ^wb_lat;
    assign w_lat = fwd_lat;
`else
    logic w_unused_lat;
    assign w_unused_lat = ^fwd_lat;
    assign w_lat = wb_lat;
`endif

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_cell
        hazard_cnt_cell #(
            .LAT_W (LAT_W)
        ) u_cell (
            .clk      (clk),
            .i_rst    (rst),
            .i_freeze (freeze),
            .i_load   (w_acc && wb_en && (dest == REG_ADDR_W'(g))),
            .i_lat    (w_lat),
            .o_cnt    (w_cnt[g])
        );
        assign w_busy[g] = |w_cnt[g];
    end

    // Old counters only, so an instruction never waits on itself.
    assign w_hit = w_busy[src1] | (two_src & w_busy[src2]);
    assign stall = ~rst & issue_valid & ~disabled & ~flush & w_hit;
    assign w_acc = issue_valid & ~stall & ~freeze & ~flush;

    assign busy_vec = rst ? '0 : w_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
        end else if (stall && !freeze && !(&r_stall_cycles)) begin
            r_stall_cycles <= r_stall_cycles + 1'b1;
        end
    end

    assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Table-driven, directed and randomized checks of hazard_scoreboard
// against a pending-write list model.
module tb_hazard_scoreboard;

    localparam int AW = 4;
    localparam int LW = 3;
    localparam int PW = 16;
    localparam int NR = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          issue_valid, disabled, freeze, flush;
    logic [AW-1:0] src1, src2, dest;
    logic          two_src, wb_en;
    logic [LW-1:0] fwd_lat, wb_lat;
    logic          stall;
    logic [NR-1:0] busy_vec;
    logic [PW-1:0] stall_cycles;

    hazard_scoreboard #(
        .REG_ADDR_W (AW),
        .LAT_W      (LW),
        .PERF_W     (PW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .issue_valid  (issue_valid),
        .disabled     (disabled),
        .freeze       (freeze),
        .flush        (flush),
        .src1         (src1),
        .src2         (src2),
        .two_src      (two_src),
        .wb_en        (wb_en),
        .dest         (dest),
        .fwd_lat      (fwd_lat),
        .wb_lat       (wb_lat),
        .stall        (stall),
        .busy_vec     (busy_vec),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Model: list of pending writes, each with cycles remaining.
    typedef struct {
        int rg;
        int rem;
    } pw_t;
    pw_t q[$];
    int  m_sc = 0;

    function automatic bit m_busy(int r);
        foreach (q[i]) if (q[i].rg == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [NR-1:0] m_vec();
        logic [NR-1:0] v = '0;
        if (rst) return '0;
        foreach (q[i]) v[q[i].rg] = 1'b1;
        return v;
    endfunction

    function automatic bit m_stall();
        if (rst || !issue_valid || disabled || flush) return 1'b0;
        return m_busy(int'(src1)) || (two_src && m_busy(int'(src2)));
    endfunction

    function automatic int m_lat();
`ifdef HAZARD_FWD_EN
        return int'(fwd_lat);
`else
        return int'(wb_lat);
`endif
    endfunction

    task automatic m_edge();
        bit st;
        bit acc;
        pw_t nq[$];
        st  = m_stall();
        acc = issue_valid && !st && !freeze && !flush;
        if (rst) begin
            q.delete();
            m_sc = 0;
        end else if (!freeze) begin
            foreach (q[i]) if (q[i].rem > 1) nq.push_back('{q[i].rg, q[i].rem - 1});
            q = nq;
            if (acc && wb_en && m_lat() > 0) q.push_back('{int'(dest), m_lat()});
            if (st && m_sc < (1 << PW) - 1) m_sc++;
        end
    endtask

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic drive(bit iv, bit dis, bit frz, bit fl, int s1, int s2,
                         bit two, bit wb, int d, int fl_l, int wb_l);
        issue_valid = iv;
        disabled    = dis;
        freeze      = frz;
        flush       = fl;
        src1        = AW'(s1);
        src2        = AW'(s2);
        two_src     = two;
        wb_en       = wb;
        dest        = AW'(d);
        fwd_lat     = LW'(fl_l);
        wb_lat      = LW'(wb_l);
    endtask

    // Compare outputs against the model mid-cycle, then advance.
    task automatic tick(string tag);
        #1;
        check({tag, ".stall"}, 32'(stall), 32'(m_stall()));
        check({tag, ".busy"}, 32'(busy_vec), 32'(m_vec()));
        check({tag, ".sc"}, 32'(stall_cycles), 32'(m_sc));
        @(posedge clk);
        m_edge();
        @(negedge clk);
    endtask

    typedef struct {
        bit iv, dis, frz, fl, two, wb;
        int s1, s2, d, lat;
        bit e_stall;
        int e_busy;
        int e_sc;
    } vec_t;
    vec_t tv[$];

    function automatic vec_t mk(bit iv, bit dis, bit frz, bit fl, int s1,
                                int s2, bit two, bit wb, int d, int lat,
                                bit es, int eb, int esc);
        vec_t v;
        v.iv = iv; v.dis = dis; v.frz = frz; v.fl = fl;
        v.s1 = s1; v.s2 = s2; v.two = two; v.wb = wb;
        v.d = d; v.lat = lat;
        v.e_stall = es; v.e_busy = eb; v.e_sc = esc;
        return v;
    endfunction

    initial begin
        bit exp_st;
        rst = 1'b1;
        drive(1, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        tick("rst");
        rst = 1'b0;

        //     iv d fz fl s1 s2 tw wb de lat  stall busy      sc
        tv.push_back(mk(1,0,0,0, 3,0,0,0, 0,0, 0,0,        0));
        tv.push_back(mk(1,0,0,0, 0,0,0,1, 5,2, 0,0,        0));
        tv.push_back(mk(1,0,0,0, 5,0,0,0, 0,0, 1,1<<5,     0));
        tv.push_back(mk(1,0,0,0, 5,0,0,0, 0,0, 1,1<<5,     1));
        tv.push_back(mk(1,0,0,0, 5,0,0,0, 0,0, 0,0,        2));
        tv.push_back(mk(1,0,0,0, 0,0,0,1, 7,5, 0,0,        2));
        tv.push_back(mk(1,0,0,0, 0,0,0,1, 7,1, 0,1<<7,     2));
        tv.push_back(mk(1,0,0,0, 7,0,0,0, 0,0, 1,1<<7,     2));
        tv.push_back(mk(1,0,0,0, 7,0,0,0, 0,0, 1,1<<7,     3));
        tv.push_back(mk(1,0,0,0, 7,0,0,0, 0,0, 1,1<<7,     4));
        tv.push_back(mk(1,0,0,0, 7,0,0,0, 0,0, 1,1<<7,     5));
        tv.push_back(mk(1,0,0,0, 7,0,0,0, 0,0, 0,0,        6));
        tv.push_back(mk(1,0,0,0, 0,0,0,1, 2,2, 0,0,        6));
        tv.push_back(mk(1,0,1,0, 2,0,0,0, 0,0, 1,1<<2,     6));
        tv.push_back(mk(1,0,1,0, 2,0,0,0, 0,0, 1,1<<2,     6));
        tv.push_back(mk(1,0,1,0, 2,0,0,0, 0,0, 1,1<<2,     6));
        tv.push_back(mk(1,0,0,0, 2,0,0,0, 0,0, 1,1<<2,     6));
        tv.push_back(mk(1,0,0,0, 2,0,0,0, 0,0, 1,1<<2,     7));
        tv.push_back(mk(1,0,0,0, 2,0,0,0, 0,0, 0,0,        8));
        tv.push_back(mk(1,0,0,0, 0,0,0,1, 9,3, 0,0,        8));
        tv.push_back(mk(1,0,0,0, 0,9,0,0, 0,0, 0,1<<9,     8));
        tv.push_back(mk(1,1,0,0, 9,0,0,0, 0,0, 0,1<<9,     8));
        tv.push_back(mk(1,0,0,1, 9,0,0,1,11,3, 0,1<<9,     8));
        tv.push_back(mk(1,0,0,0,11,9,1,0, 0,0, 0,0,        8));
        tv.push_back(mk(1,0,0,0, 3,3,0,1, 3,4, 0,0,        8));
        tv.push_back(mk(1,0,0,0, 1,3,1,0, 0,0, 1,1<<3,     8));

        foreach (tv[i]) begin
            drive(tv[i].iv, tv[i].dis, tv[i].frz, tv[i].fl, tv[i].s1,
                  tv[i].s2, tv[i].two, tv[i].wb, tv[i].d, tv[i].lat,
                  tv[i].lat);
            #1;
            check($sformatf("tv%0d.stall", i), 32'(stall), 32'(tv[i].e_stall));
            check($sformatf("tv%0d.busy", i), 32'(busy_vec), 32'(tv[i].e_busy));
            check($sformatf("tv%0d.sc", i), 32'(stall_cycles), 32'(tv[i].e_sc));
            tick($sformatf("tv%0d", i));
        end

        // Drain, then mid-stall reset.
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (8) tick("drain");
        drive(1, 0, 0, 0, 0, 0, 0, 1, 4, 3, 3);
        tick("rs.wr");
        drive(1, 0, 0, 0, 4, 0, 0, 0, 0, 0, 0);
        #1;
        check("rs.stall_pre", 32'(stall), 32'd1);
        tick("rs.stall");
        rst = 1'b1;
        #1;
        check("rs.stall_in_rst", 32'(stall), 32'd0);
        check("rs.busy_in_rst", 32'(busy_vec), 32'd0);
        tick("rs.rst");
        rst = 1'b0;
        #1;
        check("rs.stall_post", 32'(stall), 32'd0);
        check("rs.sc_post", 32'(stall_cycles), 32'd0);
        tick("rs.post");

        // ALU result: forwardable immediately, written back in 2.
        drive(1, 0, 0, 0, 0, 0, 0, 1, 6, LAT_ALU_FWD_I(), 2);
        tick("alu.wr");
        drive(1, 0, 0, 0, 6, 0, 0, 0, 0, 0, 0);
`ifdef HAZARD_FWD_EN
        exp_st = 1'b0;
`else
        exp_st = 1'b1;
`endif
        #1;
        check("alu.rd", 32'(stall), 32'(exp_st));
        tick("alu.rd");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (8) tick("drain2");

        // Random mix, biased to a few registers to create hazards.
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 99) < 2);
            drive($urandom_range(0, 9) < 8, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 5), $urandom_range(0, 5),
                  $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 5), $urandom_range(0, 7),
                  $urandom_range(0, 7));
            tick("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    function automatic int LAT_ALU_FWD_I();
        return hazard_pkg::LAT_ALU_FWD;
    endfunction

endmodule
